// File: rtl/riscv_hwloop_pkg.sv
// rtl/riscv_hwloop_pkg.sv - shared constants for the hardware-loop sequencer
package riscv_hwloop_pkg;

  localparam int DEFAULT_N_REGS = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_REARM = 2'd2;

endpackage

// File: rtl/riscv_hwloop_sequencer_match.sv
// rtl/riscv_hwloop_sequencer_match.sv - per-loop end-address compare with lowest-index priority
module riscv_hwloop_match
  import riscv_hwloop_pkg::*;
#(
  parameter int N_REGS     = DEFAULT_N_REGS,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic [31:0]             pc,
  input  logic                    pc_valid,
  input  logic [N_REGS-1:0][31:0] end_addr,
  input  logic [N_REGS-1:0][31:0] counter,
  output logic                    match,
  output logic [N_REG_BITS-1:0]   idx,
  output logic                    jump
);

  // Scan from the highest index down so the innermost (lowest) loop overwrites.
  always_comb begin
    match = 1'b0;
    idx   = '0;
    jump  = 1'b0;
    for (int k = N_REGS - 1; k >= 0; k--) begin
      if (pc_valid && (pc == end_addr[k]) && (counter[k] != 32'd0)) begin
        match = 1'b1;
        idx   = k[N_REG_BITS-1:0];
        jump  = (counter[k] > 32'd1);
      end
    end
  end

endmodule

// File: rtl/riscv_hwloop_sequencer.sv
// rtl/riscv_hwloop_sequencer.sv - end-of-loop detection, jump request and counter decrement sequencing
module riscv_hwloop_sequencer
  import riscv_hwloop_pkg::*;
#(
  parameter int N_REGS     = DEFAULT_N_REGS,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    setback_i,
  input  logic [31:0]             current_pc_i,
  input  logic                    pc_valid_i,
  input  logic [N_REGS-1:0][31:0] hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_counter_i,
  input  logic                    fetch_ready_i,
  input  logic                    valid_i,
  output logic                    hwlp_jump_o,
  output logic [31:0]             hwlp_targ_addr_o,
  output logic [N_REGS-1:0]       hwlp_dec_cnt_o,
  output logic                    hwlp_busy_o
);

  logic [1:0]            state;
  logic [31:0]           cap_pc;
  logic [N_REG_BITS-1:0] cap_idx;
  logic [31:0]           cap_targ;
  logic                  jump_pending;
  logic                  dec_pending;

  logic                  match;
  logic [N_REG_BITS-1:0] match_idx;
  logic                  match_jump;

  logic                  jump_accept;
  logic                  jump_done;
  logic                  dec_done;

  riscv_hwloop_match #(
    .N_REGS     (N_REGS),
    .N_REG_BITS (N_REG_BITS)
  ) u_match (
    .pc       (current_pc_i),
    .pc_valid (pc_valid_i),
    .end_addr (hwlp_end_addr_i),
    .counter  (hwlp_counter_i),
    .match    (match),
    .idx      (match_idx),
    .jump     (match_jump)
  );

  assign hwlp_jump_o      = (state == ST_WAIT) && jump_pending;
  assign hwlp_targ_addr_o = cap_targ;
  assign hwlp_busy_o      = (state != ST_IDLE);

  assign jump_accept = hwlp_jump_o && fetch_ready_i;
  assign jump_done   = !jump_pending || jump_accept;
  assign dec_done    = !dec_pending || valid_i;

  always_comb begin
    hwlp_dec_cnt_o = '0;
    if ((state == ST_WAIT) && dec_pending) begin
      hwlp_dec_cnt_o[cap_idx] = 1'b1;
    end
  end

  // A flush and a reset both drop everything captured; only rst is a true reset.
  always_ff @(posedge clk) begin
    if (rst || setback_i) begin
      state        <= ST_IDLE;
      cap_pc       <= '0;
      cap_idx      <= '0;
      cap_targ     <= '0;
      jump_pending <= 1'b0;
      dec_pending  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (match) begin
            state        <= ST_WAIT;
            cap_pc       <= current_pc_i;
            cap_idx      <= match_idx;
            cap_targ     <= hwlp_start_addr_i[match_idx];
            jump_pending <= match_jump;
            dec_pending  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (jump_accept) begin
            jump_pending <= 1'b0;
          end
          if (valid_i) begin
            dec_pending <= 1'b0;
          end
          if (jump_done && dec_done) begin
            state <= ST_REARM;
          end
        end
        ST_REARM: begin
          // Hold off re-matching until the end PC has actually moved on.
          if (!pc_valid_i || (current_pc_i != cap_pc)) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_hwloop_sequencer.sv
// tb/tb_riscv_hwloop_sequencer.sv - directed-vector bench for riscv_hwloop_sequencer
module tb_riscv_hwloop_sequencer;

  logic             clk;
  logic             rst;
  logic             setback_i;
  logic [31:0]      current_pc_i;
  logic             pc_valid_i;
  logic [1:0][31:0] hwlp_start_addr_i;
  logic [1:0][31:0] hwlp_end_addr_i;
  logic [1:0][31:0] hwlp_counter_i;
  logic             fetch_ready_i;
  logic             valid_i;
  logic             hwlp_jump_o;
  logic [31:0]      hwlp_targ_addr_o;
  logic [1:0]       hwlp_dec_cnt_o;
  logic             hwlp_busy_o;

  int n_vec;
  int n_err;
  int pulses;
  int spurious;
  logic [1:0] prev_dec;

  riscv_hwloop_sequencer #(.N_REGS(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .setback_i         (setback_i),
    .current_pc_i      (current_pc_i),
    .pc_valid_i        (pc_valid_i),
    .hwlp_start_addr_i (hwlp_start_addr_i),
    .hwlp_end_addr_i   (hwlp_end_addr_i),
    .hwlp_counter_i    (hwlp_counter_i),
    .fetch_ready_i     (fetch_ready_i),
    .valid_i           (valid_i),
    .hwlp_jump_o       (hwlp_jump_o),
    .hwlp_targ_addr_o  (hwlp_targ_addr_o),
    .hwlp_dec_cnt_o    (hwlp_dec_cnt_o),
    .hwlp_busy_o       (hwlp_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    setback_i = 1'b0;
    current_pc_i = '0;
    pc_valid_i = 1'b0;
    hwlp_start_addr_i = '0;
    hwlp_end_addr_i = '0;
    hwlp_counter_i = '0;
    fetch_ready_i = 1'b0;
    valid_i = 1'b0;
    tick();
    tick();
    check("rst_jump", {31'd0, hwlp_jump_o}, 32'd0);
    check("rst_targ", hwlp_targ_addr_o, 32'd0);
    check("rst_dec", {30'd0, hwlp_dec_cnt_o}, 32'd0);
    check("rst_busy", {31'd0, hwlp_busy_o}, 32'd0);

    // Basic loop, cnt=3; loop registers scribbled while in WAIT.
    rst = 1'b0;
    hwlp_start_addr_i[0] = 32'h100;
    hwlp_end_addr_i[0] = 32'h120;
    hwlp_counter_i[0] = 32'd3;
    hwlp_end_addr_i[1] = 32'h300;
    current_pc_i = 32'h120;
    pc_valid_i = 1'b1;
    fetch_ready_i = 1'b1;
    tick();
    check("c3_jump", {31'd0, hwlp_jump_o}, 32'd1);
    check("c3_targ", hwlp_targ_addr_o, 32'h100);
    check("c3_dec", {30'd0, hwlp_dec_cnt_o}, 32'd1);
    check("c3_busy", {31'd0, hwlp_busy_o}, 32'd1);
    hwlp_counter_i[0] = 32'd0;
    hwlp_start_addr_i[0] = 32'h999;
    current_pc_i = 32'h100;
    tick();
    check("c3_jump_drop", {31'd0, hwlp_jump_o}, 32'd0);
    check("c3_dec_hold", {30'd0, hwlp_dec_cnt_o}, 32'd1);
    check("c3_targ_hold", hwlp_targ_addr_o, 32'h100);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check("c3_dec_clear", {30'd0, hwlp_dec_cnt_o}, 32'd0);
    check("c3_rearm", {31'd0, hwlp_busy_o}, 32'd1);
    tick();
    check("c3_idle", {31'd0, hwlp_busy_o}, 32'd0);
    hwlp_start_addr_i[0] = 32'h100;

    // Last iteration: cnt=1 decrements but never jumps.
    hwlp_counter_i[0] = 32'd1;
    current_pc_i = 32'h120;
    tick();
    check("c1_jump", {31'd0, hwlp_jump_o}, 32'd0);
    check("c1_dec", {30'd0, hwlp_dec_cnt_o}, 32'd1);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check("c1_dec_clear", {30'd0, hwlp_dec_cnt_o}, 32'd0);
    check("c1_rearm", {31'd0, hwlp_busy_o}, 32'd1);
    pc_valid_i = 1'b0;
    tick();
    check("c1_idle", {31'd0, hwlp_busy_o}, 32'd0);

    // Nested loops sharing an end address: loop0 wins; then flushed by setback.
    hwlp_start_addr_i[0] = 32'h180;
    hwlp_start_addr_i[1] = 32'h1c0;
    hwlp_end_addr_i[0] = 32'h200;
    hwlp_end_addr_i[1] = 32'h200;
    hwlp_counter_i[0] = 32'd5;
    hwlp_counter_i[1] = 32'd5;
    current_pc_i = 32'h200;
    pc_valid_i = 1'b1;
    fetch_ready_i = 1'b0;
    tick();
    check("nest_dec", {30'd0, hwlp_dec_cnt_o}, 32'd1);
    check("nest_targ", hwlp_targ_addr_o, 32'h180);
    check("nest_jump", {31'd0, hwlp_jump_o}, 32'd1);
    setback_i = 1'b1;
    tick();
    setback_i = 1'b0;
    pc_valid_i = 1'b0;
    check("sb_jump", {31'd0, hwlp_jump_o}, 32'd0);
    check("sb_dec", {30'd0, hwlp_dec_cnt_o}, 32'd0);
    check("sb_busy", {31'd0, hwlp_busy_o}, 32'd0);
    tick();
    check("sb_stay_idle", {31'd0, hwlp_busy_o}, 32'd0);

    // Fetch back-pressure for three cycles.
    hwlp_start_addr_i[0] = 32'h100;
    hwlp_end_addr_i[0] = 32'h120;
    hwlp_counter_i[0] = 32'd3;
    hwlp_end_addr_i[1] = 32'h300;
    hwlp_counter_i[1] = 32'd0;
    current_pc_i = 32'h120;
    pc_valid_i = 1'b1;
    fetch_ready_i = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_jump", {31'd0, hwlp_jump_o}, 32'd1);
      check("bp_targ", hwlp_targ_addr_o, 32'h100);
      if (i == 2) begin
        fetch_ready_i = 1'b1;
        valid_i = 1'b1;
      end
      tick();
    end
    valid_i = 1'b0;
    check("bp_jump_drop", {31'd0, hwlp_jump_o}, 32'd0);
    check("bp_rearm", {31'd0, hwlp_busy_o}, 32'd1);
    pc_valid_i = 1'b0;
    tick();
    check("bp_idle", {31'd0, hwlp_busy_o}, 32'd0);

    // Stalled end PC must not cause a second decrement.
    pulses = 0;
    prev_dec = '0;
    current_pc_i = 32'h120;
    pc_valid_i = 1'b1;
    fetch_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_i = (i == 1);
      tick();
      if (hwlp_dec_cnt_o != 2'b00 && prev_dec == 2'b00) pulses++;
      prev_dec = hwlp_dec_cnt_o;
    end
    valid_i = 1'b0;
    check("stall_pulses", pulses, 32'd1);
    check("stall_rearm", {31'd0, hwlp_busy_o}, 32'd1);
    pc_valid_i = 1'b0;
    tick();
    check("stall_idle", {31'd0, hwlp_busy_o}, 32'd0);

    // Reset in WAIT abandons the pending jump and decrement.
    pc_valid_i = 1'b1;
    fetch_ready_i = 1'b0;
    tick();
    check("rw_jump_pre", {31'd0, hwlp_jump_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc_valid_i = 1'b0;
    check("rw_jump", {31'd0, hwlp_jump_o}, 32'd0);
    check("rw_dec", {30'd0, hwlp_dec_cnt_o}, 32'd0);
    check("rw_busy", {31'd0, hwlp_busy_o}, 32'd0);
    check("rw_targ", hwlp_targ_addr_o, 32'd0);
    spurious = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (hwlp_jump_o || hwlp_dec_cnt_o != 2'b00) spurious++;
    end
    check("rw_no_pulse", spurious, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
